// File: rtl/seq_gen_serial.sv
// Serial pattern generator: shifts out the low i_len bits of a latched
// pattern, MSB first, one bit per clock, repeated i_repeat+1 times.
// Every output is driven straight from a flop.
module seq_gen_serial #(
  parameter int   PAT_W    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [PAT_W-1:0]             i_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   i_len,
  input  logic [3:0]                   i_repeat,
  output logic                         o_seq,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int                LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [LEN_W-1:0]   idx_q,   idx_d;
  logic [3:0]         rep_q,   rep_d;
  logic               seq_q,   seq_d;
  logic               valid_q, valid_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  logic               len_legal;
  logic [PAT_W-1:0]   shifted;

  assign len_legal = (i_len != '0) && (i_len <= MAX_LEN);

  // Next-state and next-output logic; the flop outputs show the bit at idx_q.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    seq_d   = IDLE_BIT;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    shifted = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        // Stop overrides start: a simultaneous request is simply dropped.
        if (i_start && !i_stop) begin
          if (len_legal) begin
            pat_d   = i_pattern;
            len_d   = i_len;
            rep_d   = i_repeat;
            idx_d   = i_len - LEN_W'(1);
            shifted = i_pattern >> idx_d;
            seq_d   = shifted[0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          rep_d   = '0;
        end else begin
          if (idx_q != '0) begin
            idx_d = idx_q - LEN_W'(1);
          end else if (rep_q != '0) begin
            // Wrap straight back to the top bit so repetitions are gapless.
            rep_d = rep_q - 4'd1;
            idx_d = len_q - LEN_W'(1);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
          if (state_d == ST_SEND) begin
            shifted = pat_q >> idx_d;
            seq_d   = shifted[0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_rst) begin
      state_q <= ST_IDLE;
      // NOTE: the pattern holder is cleared too; it is a single word, so
      // resetting it is cheap and keeps the state fully deterministic.
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      seq_q   <= IDLE_BIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_seq   = seq_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Self-checking bench for seq_gen_serial: directed vector table, hand-written
// multi-cycle corner sequences, then random traffic against a queue model.
module tb_seq_gen_serial;

  localparam int PAT_W = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] pat;
  logic [3:0] len;
  logic [3:0] rep;
  logic       o_seq, o_valid, o_busy, o_done, o_err;

  int checks = 0;
  int errors = 0;

  // Expected outputs packed as {seq, valid, busy, done, err}.
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_ONE  = 5'b11100;
  localparam logic [4:0] E_ZERO = 5'b01100;
  localparam logic [4:0] E_DONE = 5'b00010;
  localparam logic [4:0] E_ERR  = 5'b00001;

  seq_gen_serial #(.PAT_W(PAT_W), .IDLE_BIT(1'b0)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_pattern (pat),
    .i_len     (len),
    .i_repeat  (rep),
    .o_seq     (o_seq),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bits still to be shown, head = bit currently on o_seq.
  bit         mq[$];
  logic [4:0] m_exp;

  task automatic model_edge();
    m_exp = E_IDLE;
    if (rst) begin
      mq.delete();
    end else if (mq.size() != 0) begin
      if (stop) begin
        mq.delete();
      end else begin
        void'(mq.pop_front());
        if (mq.size() != 0) m_exp = {mq[0], 4'b1100};
        else                m_exp = E_DONE;
      end
    end else if (start && !stop) begin
      if (int'(len) >= 1 && int'(len) <= PAT_W) begin
        for (int r = 0; r <= int'(rep); r++)
          for (int i = int'(len) - 1; i >= 0; i--)
            mq.push_back(pat[i]);
        m_exp = {mq[0], 4'b1100};
      end else begin
        m_exp = E_ERR;
      end
    end
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {seq,valid,busy,done,err}=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: the model and DUT see the same inputs; outputs sampled 1 after.
  task automatic step(input string name, input logic [4:0] exp, input bit use_model);
    @(posedge clk);
    model_edge();
    #1;
    check(name, {o_seq, o_valid, o_busy, o_done, o_err}, use_model ? m_exp : exp);
  endtask

  task automatic drive(input logic s, input logic p, input logic r,
                       input logic [7:0] pt, input logic [3:0] ln, input logic [3:0] rp);
    start = s; stop = p; rst = r; pat = pt; len = ln; rep = rp;
  endtask

  typedef struct {
    string      name;
    logic       start, stop, rst;
    logic [7:0] pat;
    logic [3:0] len, rep;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string n, logic s, logic p, logic r, logic [7:0] pt,
                             logic [3:0] ln, logic [3:0] rp, logic [4:0] e);
    vec_t x;
    x.name = n; x.start = s; x.stop = p; x.rst = r;
    x.pat = pt; x.len = ln; x.rep = rp; x.exp = e;
    return x;
  endfunction

  initial begin
    logic [8:0] bits31;

    drive(0, 0, 1, 8'h00, 4'd0, 4'd0);
    step("reset0", E_IDLE, 0);
    step("reset1", E_IDLE, 0);
    drive(0, 0, 0, 8'h00, 4'd0, 4'd0);
    step("idle", E_IDLE, 0);

    // 0x0B len 4: 1,0,1,1 then done; garbage start requests mid-send ignored.
    tbl.push_back(v("b0b_bit3", 1, 0, 0, 8'h0B, 4'd4, 4'd0, E_ONE));
    tbl.push_back(v("b0b_bit2", 1, 0, 0, 8'hF4, 4'd3, 4'd5, E_ZERO));
    tbl.push_back(v("b0b_bit1", 1, 0, 0, 8'hF4, 4'd3, 4'd5, E_ONE));
    tbl.push_back(v("b0b_bit0", 1, 0, 0, 8'hF4, 4'd3, 4'd5, E_ONE));
    tbl.push_back(v("b0b_done", 0, 0, 0, 8'h00, 4'd0, 4'd0, E_DONE));
    tbl.push_back(v("b0b_idle", 0, 0, 0, 8'h00, 4'd0, 4'd0, E_IDLE));
    // Illegal lengths rejected with a single err pulse.
    tbl.push_back(v("len0_err", 1, 0, 0, 8'hAA, 4'd0, 4'd0, E_ERR));
    tbl.push_back(v("len0_clr", 0, 0, 0, 8'hAA, 4'd0, 4'd0, E_IDLE));
    tbl.push_back(v("len9_err", 1, 0, 0, 8'hAA, 4'd9, 4'd0, E_ERR));
    tbl.push_back(v("len9_clr", 0, 0, 0, 8'hAA, 4'd9, 4'd0, E_IDLE));
    // Start and stop together: stop wins, no err.
    tbl.push_back(v("startstop", 1, 1, 0, 8'hFF, 4'd4, 4'd0, E_IDLE));
    tbl.push_back(v("startstop_bad", 1, 1, 0, 8'hFF, 4'd0, 4'd0, E_IDLE));
    // len 1 sends pattern[0] per repetition.
    tbl.push_back(v("len1_r0", 1, 0, 0, 8'hFE, 4'd1, 4'd1, E_ZERO));
    tbl.push_back(v("len1_r1", 0, 0, 0, 8'h00, 4'd0, 4'd0, E_ZERO));
    tbl.push_back(v("len1_done", 0, 0, 0, 8'h00, 4'd0, 4'd0, E_DONE));
    tbl.push_back(v("len1_idle", 0, 0, 0, 8'h00, 4'd0, 4'd0, E_IDLE));
    // Start held high: restart taken in the done cycle, one-cycle gap.
    tbl.push_back(v("hold_a1", 1, 0, 0, 8'h02, 4'd2, 4'd0, E_ONE));
    tbl.push_back(v("hold_a0", 1, 0, 0, 8'h02, 4'd2, 4'd0, E_ZERO));
    tbl.push_back(v("hold_gap", 1, 0, 0, 8'h02, 4'd2, 4'd0, E_DONE));
    tbl.push_back(v("hold_b1", 1, 0, 0, 8'h02, 4'd2, 4'd0, E_ONE));
    tbl.push_back(v("hold_b0", 1, 0, 0, 8'h02, 4'd2, 4'd0, E_ZERO));
    tbl.push_back(v("hold_done", 0, 0, 0, 8'h02, 4'd2, 4'd0, E_DONE));
    tbl.push_back(v("hold_idle", 0, 0, 0, 8'h02, 4'd2, 4'd0, E_IDLE));

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].rst, tbl[i].pat, tbl[i].len, tbl[i].rep);
      step(tbl[i].name, tbl[i].exp, 0);
    end

    // 0x05 len 3 repeat 2: nine contiguous bits, one done pulse.
    bits31 = 9'b101101101;
    drive(1, 0, 0, 8'h05, 4'd3, 4'd2);
    for (int k = 0; k < 9; k++) begin
      step("rep_bits", {bits31[8-k], 4'b1100}, 0);
      drive(0, 0, 0, 8'h05, 4'd3, 4'd2);
    end
    step("rep_done", E_DONE, 0);
    step("rep_idle", E_IDLE, 0);

    // Stop during the third bit of 0xFF: no done, then a clean restart.
    drive(1, 0, 0, 8'hFF, 4'd8, 4'd0);
    step("stop_bit1", E_ONE, 0);
    drive(0, 0, 0, 8'hFF, 4'd8, 4'd0);
    step("stop_bit2", E_ONE, 0);
    step("stop_bit3", E_ONE, 0);
    drive(0, 1, 0, 8'hFF, 4'd8, 4'd0);
    step("stop_abort", E_IDLE, 0);
    drive(0, 0, 0, 8'hFF, 4'd8, 4'd0);
    step("stop_nodone", E_IDLE, 0);
    drive(1, 0, 0, 8'h0B, 4'd4, 4'd0);
    step("restart_b3", E_ONE, 0);
    drive(0, 0, 0, 8'h00, 4'd0, 4'd0);
    step("restart_b2", E_ZERO, 0);
    step("restart_b1", E_ONE, 0);
    step("restart_b0", E_ONE, 0);
    step("restart_done", E_DONE, 0);

    // Reset during the second bit, with start and stop also high.
    drive(1, 0, 0, 8'h0B, 4'd4, 4'd0);
    step("rst_bit1", E_ONE, 0);
    drive(0, 0, 0, 8'h0B, 4'd4, 4'd0);
    step("rst_bit2", E_ZERO, 0);
    drive(1, 1, 1, 8'h0B, 4'd4, 4'd0);
    step("rst_abort", E_IDLE, 0);
    drive(1, 0, 1, 8'h0B, 4'd4, 4'd0);
    step("rst_over_start", E_IDLE, 0);
    drive(0, 0, 0, 8'h0B, 4'd4, 4'd0);
    step("rst_nodone", E_IDLE, 0);

    // Random traffic against the queue model.
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2,
            8'($urandom),
            4'($urandom_range(0, 9)),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 2)));
      step("random", E_IDLE, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
